apb_driver: RTL and testbench
=============================

APB_DRIVER -- requirements
Module: apb_driver

Interface
REQ-001 Parameter ADDR_W, default 4, APB address width.
REQ-002 Parameter DATA_W, default 8, APB data width.
REQ-003 Parameter TIMEOUT, default 16, maximum ACCESS cycles with PREADY low before abort.
REQ-004 Clocking SHALL be one clock, PCLK; reset SHALL be PRESETn, asynchronous, active-low.
REQ-005 PCLK  in  1  clock; all state changes on rising edge.
REQ-006 PRESETn  in  1  asynchronous active-low reset.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  driver can accept a command.
REQ-009 cmd_write  in  1  1=write, 0=read.
REQ-010 cmd_addr  in  ADDR_W  transfer address.
REQ-011 cmd_wdata  in  DATA_W  write data.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  DATA_W  read data; 0 for writes and aborted transfers.
REQ-014 rsp_error  out  1  PSLVERR or timeout on the completed transfer.
REQ-015 PSEL, PENABLE, PWRITE  out  1 each  APB master controls.
REQ-016 PADDR  out  ADDR_W; PWDATA  out  DATA_W  APB address/write data.
REQ-017 PRDATA  in  DATA_W; PREADY  in  1; PSLVERR  in  1  APB slave responses.

Function
REQ-018 FSM SHALL have states IDLE, SETUP, ACCESS; cmd_ready SHALL be 1 only in IDLE.
REQ-019 In IDLE, cmd_valid=1 SHALL capture cmd_write/cmd_addr/cmd_wdata and move to SETUP next edge.
REQ-020 SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA from the captured command; unconditionally to ACCESS next edge.
REQ-021 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA SHALL stay unchanged until exit.
REQ-022 ACCESS with PREADY=1 SHALL complete: next edge go to IDLE, drop PSEL/PENABLE, assert rsp_valid for exactly one cycle.
REQ-023 On a completed read, rsp_rdata SHALL be PRDATA sampled at the completing edge; on a write, rsp_rdata=0.
REQ-024 rsp_error SHALL be PSLVERR sampled at the completing edge.
REQ-025 ACCESS with PREADY=0 SHALL remain in ACCESS, counting cycles; after TIMEOUT consecutive PREADY=0 cycles the driver SHALL abort to IDLE with rsp_valid=1, rsp_error=1, rsp_rdata=0.
REQ-026 rsp_rdata/rsp_error SHALL hold their values until the next rsp_valid.
REQ-027 Minimum transfer: accept edge to rsp_valid = 3 edges; a new command SHALL be acceptable in the same cycle rsp_valid is high.
REQ-028 In IDLE, PADDR/PWRITE/PWDATA SHALL hold last transfer values; PSEL=PENABLE=0.
REQ-029 cmd_valid outside IDLE SHALL be ignored; the requester holds it until cmd_ready.
REQ-030 PENABLE SHALL never be 1 while PSEL=0.

Reset
REQ-031 PRESETn low SHALL immediately force IDLE: PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0, rsp_valid=rsp_error=0, rsp_rdata=0, timeout counter=0, cmd_ready=1.
REQ-032 Reset during SETUP/ACCESS SHALL abandon the transfer with no rsp_valid.

Verification
REQ-033 Reset: PRESETn=0 -> all APB outputs and rsp_* 0, cmd_ready=1.
REQ-034 Write addr 4'h1 data 8'hAA, PREADY=1 -> one SETUP cycle (PSEL=1, PENABLE=0, PWRITE=1, PADDR=1, PWDATA=AA), one ACCESS cycle, rsp_valid pulse, rsp_error=0.
REQ-035 With bench memory slave: write 1<-AA, write 2<-55, read 1 -> rsp_rdata=8'hAA; read 2 -> 8'h55.
REQ-036 PREADY low 3 cycles in ACCESS -> ACCESS lasts 4 cycles, PADDR/PWDATA stable, single rsp_valid.
REQ-037 Read with PSLVERR=1 at completion -> rsp_error=1; PREADY never high -> abort after 16 ACCESS cycles, rsp_error=1, rsp_rdata=0.
REQ-038 PRESETn pulsed low during ACCESS -> PSEL/PENABLE drop immediately, no rsp_valid, next command runs normally.

Source files
------------

// File: rtl/apb_driver.sv
// Single-outstanding APB master: takes one command at a time from a valid/ready
// request port, runs the SETUP/ACCESS handshake and reports a one-cycle response.
module apb_driver #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response side
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  // APB master
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;
  logic             accept;
  logic             done_ok;
  logic             abort;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    accept       = 1'b0;
    done_ok      = 1'b0;
    abort        = 1'b0;
    cmd_ready    = 1'b0;
    PSEL         = 1'b0;
    PENABLE      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready    = 1'b1;
        wait_cnt_nxt = '0;
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        PSEL         = 1'b1;
        wait_cnt_nxt = '0;
        state_nxt    = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY) begin
          done_ok      = 1'b1;
          wait_cnt_nxt = '0;
          state_nxt    = IDLE;
        // wait_cnt holds the number of stalled cycles already seen, so this
        // cycle is stall number TIMEOUT when the count reaches TIMEOUT-1
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          abort        = 1'b1;
          wait_cnt_nxt = '0;
          state_nxt    = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Captured command drives the bus from SETUP until the next accept.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
    end else if (accept) begin
      PWRITE <= cmd_write;
      PADDR  <= cmd_addr;
      PWDATA <= cmd_wdata;
    end
  end

  // Response data/error persist until the next completion.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= done_ok | abort;
      if (done_ok) begin
        rsp_rdata <= PWRITE ? '0 : PRDATA;
        rsp_error <= PSLVERR;
      end else if (abort) begin
        rsp_rdata <= '0;
        rsp_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_driver.sv
// Directed bench for apb_driver: a small memory slave with programmable wait
// states and error, plus a scoreboard of expected responses.
module tb_apb_driver;

  logic       PCLK;
  logic       PRESETn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_error;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [3:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  apb_driver #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Memory slave with programmable behaviour
  int         wait_cycles;
  logic       slverr_en;
  logic       never_ready;
  int         slv_cnt;
  logic [7:0] mem [16];

  assign PREADY  = PSEL && PENABLE && !never_ready && (slv_cnt >= wait_cycles);
  assign PSLVERR = PREADY && slverr_en;
  assign PRDATA  = mem[PADDR];

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) slv_cnt <= slv_cnt + 1;
    else                            slv_cnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR) mem[PADDR] <= PWDATA;
  end

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] ref_mem [16];
  int         total;
  int         passes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called just after a falling edge; returns at the falling edge where
  // rsp_valid is seen so the next call can issue back-to-back.
  task automatic xfer(input logic wr, input logic [3:0] a, input logic [7:0] d,
                      input int waits, input logic err, input logic hang);
    exp_t e;
    int   acc;
    int   lat;
    bit   seen;
    wait_cycles = waits;
    slverr_en   = err;
    never_ready = hang;
    cmd_valid   = 1'b1;
    cmd_write   = wr;
    cmd_addr    = a;
    cmd_wdata   = d;
    chk("accept_ready", cmd_ready, 1);
    e.rdata = (wr || hang) ? 8'h00 : ref_mem[a];
    e.err   = hang || err;
    if (wr && !hang && !err) ref_mem[a] = d;
    sbq.push_back(e);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    chk("setup_psel", PSEL, 1);
    chk("setup_penable", PENABLE, 0);
    chk("setup_pwrite", PWRITE, wr);
    chk("setup_paddr", PADDR, a);
    chk("setup_pwdata", PWDATA, d);
    chk("setup_ready", cmd_ready, 0);
    chk("setup_rspv", rsp_valid, 0);
    acc  = 0;
    lat  = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge PCLK);
      lat++;
      chk("penable_psel", PENABLE & ~PSEL, 0);
      if (PSEL && PENABLE) begin
        acc++;
        chk("access_paddr", PADDR, a);
        chk("access_pwdata", PWDATA, d);
        chk("access_rspv", rsp_valid, 0);
      end
      if (rsp_valid) begin
        seen = 1;
        chk("done_psel", PSEL, 0);
        chk("done_ready", cmd_ready, 1);
        if (sbq.size() == 0) chk("sb_empty", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_error", rsp_error, e.err);
        end
      end
    end
    if (!seen) chk("rsp_timeout", 0, 1);
    chk("access_cycles", acc, hang ? 16 : waits + 1);
    chk("latency", lat, (hang ? 16 : waits + 1) + 1);
  endtask

  initial begin
    total       = 0;
    passes      = 0;
    wait_cycles = 0;
    slverr_en   = 1'b0;
    never_ready = 1'b0;
    PRESETn     = 1'b0;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = 4'h0;
    cmd_wdata   = 8'h00;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;

    repeat (2) @(negedge PCLK);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_rerr", rsp_error, 0);
    chk("rst_ready", cmd_ready, 1);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // Minimum-latency write, then back-to-back traffic
    xfer(1'b1, 4'h1, 8'hAA, 0, 1'b0, 1'b0);
    xfer(1'b1, 4'h2, 8'h55, 0, 1'b0, 1'b0);
    xfer(1'b0, 4'h1, 8'h00, 0, 1'b0, 1'b0);
    xfer(1'b0, 4'h2, 8'h00, 0, 1'b0, 1'b0);

    // Wait states
    xfer(1'b1, 4'h5, 8'h3C, 3, 1'b0, 1'b0);
    xfer(1'b0, 4'h5, 8'h00, 2, 1'b0, 1'b0);

    // Slave error keeps the read data; response holds while idle
    xfer(1'b0, 4'h2, 8'h00, 0, 1'b1, 1'b0);
    @(negedge PCLK);
    chk("hold_rspv", rsp_valid, 0);
    chk("hold_rdata", rsp_rdata, 8'h55);
    chk("hold_rerr", rsp_error, 1);
    chk("idle_psel", PSEL, 0);
    chk("idle_paddr", PADDR, 4'h2);

    // Timeout abort, then a clean write clears the error
    xfer(1'b0, 4'h1, 8'h00, 0, 1'b0, 1'b1);
    xfer(1'b1, 4'h6, 8'h99, 1, 1'b0, 1'b0);

    // Reset in the middle of ACCESS
    wait_cycles = 10;
    slverr_en   = 1'b0;
    never_ready = 1'b0;
    cmd_valid   = 1'b1;
    cmd_write   = 1'b1;
    cmd_addr    = 4'h3;
    cmd_wdata   = 8'h33;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    chk("pre_rst_access", PSEL & PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("async_psel", PSEL, 0);
    chk("async_penable", PENABLE, 0);
    chk("async_ready", cmd_ready, 1);
    chk("async_paddr", PADDR, 0);
    @(negedge PCLK);
    chk("rst_no_rspv0", rsp_valid, 0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("rst_no_rspv1", rsp_valid, 0);
    xfer(1'b0, 4'h5, 8'h00, 0, 1'b0, 1'b0);
    xfer(1'b0, 4'h1, 8'h00, 0, 1'b0, 1'b0);
    chk("sb_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
